axil_cmd_master: RTL and testbench
==================================

Name: axil_cmd_master

Overview:
- AXI4-Lite master engine that sits directly upstream of the team's AXI-Lite register slave.
- Converts a simple one-outstanding command/response interface into complete AXI-Lite write and read transactions.
- Drives the slave's AW/W/B/AR/R channels and returns read data and response codes to the requester.
- Keeps a saturating count of error responses for debug.

Parameters:
- DATA_WIDTH, 32: data bus width in bits.
- ADDR_WIDTH, 8: address width in bits.
- RESP_WIDTH, 3: width of the bresp/rresp fields; value 0 = OKAY, any non-zero value = error.
- ERR_CNT_WIDTH, 16: width of the error counter.

Ports:
- m3_axi_aclk  in  1  clock
- m3_axi_aresetn  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts the response
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  RESP_WIDTH  captured bresp or rresp
- err_count  out  ERR_CNT_WIDTH  number of non-zero responses
- m3_axi_awaddr  out  ADDR_WIDTH
- m3_axi_awvalid  out  1
- m3_axi_awready  in  1
- m3_axi_wdata  out  DATA_WIDTH
- m3_axi_wstrb  out  DATA_WIDTH/8
- m3_axi_wvalid  out  1
- m3_axi_wready  in  1
- m3_axi_bresp  in  RESP_WIDTH
- m3_axi_bvalid  in  1
- m3_axi_bready  out  1
- m3_axi_araddr  out  ADDR_WIDTH
- m3_axi_arvalid  out  1
- m3_axi_arready  in  1
- m3_axi_rdata  in  DATA_WIDTH
- m3_axi_rresp  in  RESP_WIDTH
- m3_axi_rvalid  in  1
- m3_axi_rready  out  1

Behaviour:
- Reset values: FSM in IDLE. All outputs are registered and reset to 0, except cmd_ready, which is 1 in IDLE.
- Reset is asynchronous. Asserting it mid-transaction drops every valid/ready immediately, returns the FSM to IDLE and clears err_count.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch addr/wdata/wstrb/write.
  - Next state is WR_REQ or RD_REQ.
  - Write: awaddr, wdata and wstrb are loaded.
  - Read: araddr is loaded.
- WR_REQ:
  - awvalid and wvalid are asserted the cycle after acceptance.
  - Each is tracked by its own done flag and deasserted the cycle after its own handshake.
  - AW and W may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP.
  - Address, data and strobe stay stable while valid is high.
- WR_RESP: bready=1. On bvalid, capture bresp into rsp_resp, set rsp_write=1 and rsp_rdata=0, then go to RSP.
- RD_REQ: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp, set rsp_write=0, then go to RSP.
- RSP: rsp_valid=1, with rsp_* held stable until rsp_ready; then go to IDLE.
- bready and rready are asserted only in WR_RESP and RD_DATA. A bvalid/rvalid arriving earlier is ignored; the slave holds it.
- Minimum latency, with all slave readies/valids high, measured from the command handshake at cycle 0:
  - AXI valid at cycle 1.
  - Response state entered at cycle 2.
  - rsp_valid at cycle 3.
  - cmd_ready again the cycle after the rsp handshake.
- Only one transaction is outstanding. cmd_ready=0 in every state except IDLE, and commands presented then are not taken.
- err_count increments by 1 on each captured response ≠0. It saturates at all-ones and does not wrap.
- cmd_valid is ignored while cmd_ready=0.

Test Plan:
- Write addr 0x00, wdata 25, wstrb 0xF; slave readies high, bresp 0 → awvalid/wvalid high for exactly 1 cycle; rsp_valid at cycle 3 with rsp_write=1, rsp_resp=0; err_count=0.
- Write addr 0x04, data 34; awready delayed 3 cycles, wready immediate → wvalid high 1 cycle, awvalid high 4 cycles, bready asserted only after both handshakes, one response.
- Read addr 0x04; slave returns rdata 34 two cycles after arready → rready held until rvalid; rsp_rdata=34, rsp_write=0, rsp_resp=0.
- Read addr 0x08 with rresp=2, then write with bresp=3 → rsp_resp 2 then 3; err_count increments to 1, then 2.
- Hold rsp_ready low 5 cycles → rsp_valid and rsp_* stable, cmd_ready=0, a second cmd_valid is not accepted; on release, IDLE next cycle.
- Deassert m3_axi_aresetn while awvalid=1 → awvalid and wvalid drop immediately, cmd_ready=1 after release, err_count=0.

Source files
------------

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: one-outstanding cmd/rsp to AXI4-Lite master; ports: cmd_* in, rsp_* out, err_count debug, m3_axi_* AW/W/B/AR/R master
module axil_cmd_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int RESP_WIDTH    = 3,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                      m3_axi_aclk,
  input  logic                      m3_axi_aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [RESP_WIDTH-1:0]     rsp_resp,
  output logic [ERR_CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0]     m3_axi_awaddr,
  output logic                      m3_axi_awvalid,
  input  logic                      m3_axi_awready,
  output logic [DATA_WIDTH-1:0]     m3_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m3_axi_wstrb,
  output logic                      m3_axi_wvalid,
  input  logic                      m3_axi_wready,
  input  logic [RESP_WIDTH-1:0]     m3_axi_bresp,
  input  logic                      m3_axi_bvalid,
  output logic                      m3_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m3_axi_araddr,
  output logic                      m3_axi_arvalid,
  input  logic                      m3_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m3_axi_rdata,
  input  logic [RESP_WIDTH-1:0]     m3_axi_rresp,
  input  logic                      m3_axi_rvalid,
  output logic                      m3_axi_rready
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
  state_t state;
  logic aw_done, w_done, capture;
  logic [RESP_WIDTH-1:0] resp_in;
  assign aw_done = !m3_axi_awvalid || m3_axi_awready;
  assign w_done  = !m3_axi_wvalid || m3_axi_wready;
  assign capture = (state == WR_RESP && m3_axi_bvalid) || (state == RD_DATA && m3_axi_rvalid);
  assign resp_in = state == WR_RESP ? m3_axi_bresp : m3_axi_rresp;
  always_ff @(posedge m3_axi_aclk or negedge m3_axi_aresetn)
    if (!m3_axi_aresetn) begin
      state          <= IDLE;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= '0;
      err_count      <= '0;
      m3_axi_awaddr  <= '0;
      m3_axi_awvalid <= 1'b0;
      m3_axi_wdata   <= '0;
      m3_axi_wstrb   <= '0;
      m3_axi_wvalid  <= 1'b0;
      m3_axi_bready  <= 1'b0;
      m3_axi_araddr  <= '0;
      m3_axi_arvalid <= 1'b0;
      m3_axi_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          if (cmd_write) begin
            m3_axi_awaddr  <= cmd_addr;
            m3_axi_wdata   <= cmd_wdata;
            m3_axi_wstrb   <= cmd_wstrb;
            m3_axi_awvalid <= 1'b1;
            m3_axi_wvalid  <= 1'b1;
            state          <= WR_REQ;
          end else begin
            m3_axi_araddr  <= cmd_addr;
            m3_axi_arvalid <= 1'b1;
            state          <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (m3_axi_awready) m3_axi_awvalid <= 1'b0;
          if (m3_axi_wready) m3_axi_wvalid <= 1'b0;
          if (aw_done && w_done) begin
            m3_axi_bready <= 1'b1;
            state         <= WR_RESP;
          end
        end
        WR_RESP: if (m3_axi_bvalid) begin
          m3_axi_bready <= 1'b0;
          rsp_valid     <= 1'b1;
          rsp_write     <= 1'b1;
          rsp_rdata     <= '0;
          rsp_resp      <= m3_axi_bresp;
          state         <= RSP;
        end
        RD_REQ: if (m3_axi_arready) begin
          m3_axi_arvalid <= 1'b0;
          m3_axi_rready  <= 1'b1;
          state          <= RD_DATA;
        end
        RD_DATA: if (m3_axi_rvalid) begin
          m3_axi_rready <= 1'b0;
          rsp_valid     <= 1'b1;
          rsp_write     <= 1'b0;
          rsp_rdata     <= m3_axi_rdata;
          rsp_resp      <= m3_axi_rresp;
          state         <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (capture && resp_in != '0 && err_count != '1) err_count <= err_count + ERR_CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: table-driven and randomized check of axil_cmd_master against a reactive AXI-Lite slave model
module tb_axil_cmd_master;
  localparam int DW = 32, AW = 8, RW = 3, EW = 3;
  localparam int ERR_MAX = (1 << EW) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [RW-1:0] rsp_resp;
  logic [EW-1:0] err_count;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [RW-1:0] bresp, rresp;
  always #5 clk = ~clk;
  axil_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .ERR_CNT_WIDTH(EW)) dut (
    .m3_axi_aclk(clk), .m3_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .err_count(err_count),
    .m3_axi_awaddr(awaddr), .m3_axi_awvalid(awvalid), .m3_axi_awready(awready),
    .m3_axi_wdata(wdata), .m3_axi_wstrb(wstrb), .m3_axi_wvalid(wvalid), .m3_axi_wready(wready),
    .m3_axi_bresp(bresp), .m3_axi_bvalid(bvalid), .m3_axi_bready(bready),
    .m3_axi_araddr(araddr), .m3_axi_arvalid(arvalid), .m3_axi_arready(arready),
    .m3_axi_rdata(rdata), .m3_axi_rresp(rresp), .m3_axi_rvalid(rvalid), .m3_axi_rready(rready)
  );
  typedef struct {
    logic write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    int aw_dly, w_dly, ar_dly, d_dly;
    logic [RW-1:0] resp;
    logic [DW-1:0] rdata;
    int hold;
    logic stray;
    logic [DW-1:0] exp_rdata;
    int exp_err, exp_aw, exp_w, exp_ar, exp_lat;
  } vec_t;
  int checks = 0, failures = 0, err_model = 0;
  vec_t tbl[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; arready = 0; rvalid = 0; rresp = '0; rdata = '0;
  endtask
  function automatic vec_t mk(logic wr, logic [AW-1:0] a, logic [DW-1:0] d, logic [DW/8-1:0] s,
                              int awd, int wd, int ard, int dd, logic [RW-1:0] r, logic [DW-1:0] rd,
                              int h, logic st, logic [DW-1:0] e_rd, int e_err, int e_aw, int e_w,
                              int e_ar, int e_lat);
    vec_t v;
    v.write = wr; v.addr = a; v.wdata = d; v.wstrb = s;
    v.aw_dly = awd; v.w_dly = wd; v.ar_dly = ard; v.d_dly = dd;
    v.resp = r; v.rdata = rd; v.hold = h; v.stray = st;
    v.exp_rdata = e_rd; v.exp_err = e_err; v.exp_aw = e_aw; v.exp_w = e_w; v.exp_ar = e_ar; v.exp_lat = e_lat;
    return v;
  endfunction
  task automatic run(input vec_t v);
    int aw_c = 0, w_c = 0, ar_c = 0, aw_wt = 0, w_wt = 0, ar_wt = 0, d_wt = 0, hold_c = 0, lat = -1, cyc = 0;
    logic aw_dn = 0, w_dn = 0, ar_dn = 0, aw_hs = 0, w_hs = 0, ar_hs = 0, d_hs = 0, d_sent = 0, rsp_hs = 0;
    logic bad_b = 0, bad_r = 0, rsp_bad = 0, busy_bad = 0, stable_bad = 0, done = 0;
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    @(negedge clk);
    cyc = 1;
    cmd_valid = v.stray; cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
    cmd_wdata = $urandom; cmd_wstrb = (DW/8)'($urandom);
    while (!done && cyc < 80) begin
      aw_dn |= aw_hs; w_dn |= w_hs; ar_dn |= ar_hs;
      if (d_hs) begin bvalid = 0; rvalid = 0; d_hs = 0; end
      if (rsp_hs) begin
        rsp_ready = 0; cmd_valid = 0;
        chk("cmd_ready_after_rsp", cmd_ready, 1);
        chk("rsp_valid_dropped", rsp_valid, 0);
        done = 1;
      end else begin
        if (cmd_ready) busy_bad = 1;
        if (awvalid) begin aw_c++; if (awaddr !== v.addr) stable_bad = 1; end
        if (wvalid) begin w_c++; if (wdata !== v.wdata || wstrb !== v.wstrb) stable_bad = 1; end
        if (arvalid) begin ar_c++; if (araddr !== v.addr) stable_bad = 1; end
        if (bready && !(aw_dn && w_dn)) bad_b = 1;
        if (rready && !ar_dn) bad_r = 1;
        if (rsp_valid) begin
          if (lat < 0) lat = cyc;
          if (rsp_write !== v.write || rsp_rdata !== v.exp_rdata || rsp_resp !== v.resp) rsp_bad = 1;
        end
        awready = awvalid && aw_wt >= v.aw_dly; if (awvalid) aw_wt++; aw_hs = awvalid && awready;
        wready = wvalid && w_wt >= v.w_dly; if (wvalid) w_wt++; w_hs = wvalid && wready;
        arready = arvalid && ar_wt >= v.ar_dly; if (arvalid) ar_wt++; ar_hs = arvalid && arready;
        if (!d_sent && (v.write ? (aw_dn && w_dn) : ar_dn)) begin
          if (d_wt >= v.d_dly) begin
            if (v.write) begin bvalid = 1; bresp = v.resp; end
            else begin rvalid = 1; rresp = v.resp; rdata = v.rdata; end
          end else d_wt++;
        end
        if ((bvalid && bready) || (rvalid && rready)) begin d_hs = 1; d_sent = 1; end
        rsp_ready = rsp_valid && hold_c >= v.hold;
        if (rsp_valid && !rsp_ready) hold_c++;
        rsp_hs = rsp_ready;
        @(negedge clk);
        cyc++;
      end
    end
    chk("txn_done", done, 1);
    chk("aw_cycles", aw_c, v.exp_aw);
    chk("w_cycles", w_c, v.exp_w);
    chk("ar_cycles", ar_c, v.exp_ar);
    chk("rsp_latency", lat, v.exp_lat);
    chk("bready_early", bad_b, 0);
    chk("rready_early", bad_r, 0);
    chk("rsp_fields", rsp_bad, 0);
    chk("cmd_ready_busy", busy_bad, 0);
    chk("req_stable", stable_bad, 0);
    chk("err_count", err_count, v.exp_err);
    @(negedge clk);
    chk("stray_not_taken", {cmd_ready, awvalid, wvalid, arvalid}, 4'b1000);
    if (done) err_model = v.exp_err;
    else begin
      idle_inputs();
      rst_n = 0; @(negedge clk); rst_n = 1; @(negedge clk);
      err_model = 0;
    end
  endtask
  initial begin
    vec_t v;
    idle_inputs();
    tbl[0] = mk(1, 8'h00, 25, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3);
    tbl[1] = mk(1, 8'h04, 34, 4'hF, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 6);
    tbl[2] = mk(0, 8'h04, 0, 4'h0, 0, 0, 0, 2, 0, 34, 0, 0, 34, 0, 0, 0, 1, 5);
    tbl[3] = mk(0, 8'h08, 0, 4'h0, 0, 0, 0, 0, 2, 32'h12345678, 0, 0, 32'h12345678, 1, 0, 0, 1, 3);
    tbl[4] = mk(1, 8'h0C, 32'hA5A5A5A5, 4'h3, 0, 0, 0, 0, 3, 32'hFFFF, 0, 0, 0, 2, 1, 1, 0, 3);
    tbl[5] = mk(1, 8'h10, 32'h77, 4'h8, 0, 2, 0, 0, 0, 0, 5, 1, 0, 2, 1, 3, 0, 5);
    tbl[6] = mk(0, 8'h14, 0, 4'h0, 0, 0, 1, 1, 0, 32'hCAFEF00D, 1, 0, 32'hCAFEF00D, 2, 0, 0, 2, 5);
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_flags", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write}, 0);
    chk("reset_data", {rsp_rdata, rsp_resp, err_count, awaddr, araddr, wdata, wstrb}, 0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run(tbl[i]);
    for (int i = 0; i < 40; i++) begin
      int m;
      logic [DW-1:0] rd;
      v.write = 1'($urandom_range(0, 1));
      rd = $urandom;
      v = mk(v.write, AW'($urandom), $urandom, (DW/8)'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1) ? RW'($urandom_range(1, ERR_MAX)) : RW'(0), rd,
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0);
      m = v.aw_dly > v.w_dly ? v.aw_dly : v.w_dly;
      v.exp_rdata = v.write ? '0 : rd;
      v.exp_err = err_model + (v.resp != 0 ? 1 : 0);
      if (v.exp_err > ERR_MAX) v.exp_err = ERR_MAX;
      v.exp_aw = v.write ? v.aw_dly + 1 : 0;
      v.exp_w = v.write ? v.w_dly + 1 : 0;
      v.exp_ar = v.write ? 0 : v.ar_dly + 1;
      v.exp_lat = 3 + v.d_dly + (v.write ? m : v.ar_dly);
      run(v);
    end
    chk("err_before_reset", err_count, err_model);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h30; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    chk("awvalid_before_reset", {awvalid, wvalid}, 2'b11);
    #2 rst_n = 0;
    #1;
    chk("reset_drops_valid", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1;
    err_model = 0;
    @(negedge clk);
    chk("after_reset_idle", {cmd_ready, awvalid, wvalid}, 3'b100);
    run(mk(1, 8'h20, 32'h55, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
